// File: rtl/conv_gpio_ctrl.sv
// ---------------------------------------------------------------------------
// conv_gpio_ctrl
//
// Command sequencer sitting between the MicroBlaze 32-bit GPIO pair and the
// 2D-convolution datapath. The host writes command words on i_gpio_cmd and
// flips bit 28 (strobe) to issue a new command. The block loads kernel
// coefficients, streams pixels into the image RAM, starts convolution runs,
// and reads results back one word at a time. Status is returned on
// o_gpio_rsp as {busy, done, error, ack, 0..., read data}.
//
// Ports:
//   CLK100MHZ      system clock
//   ck_rst         asynchronous active-low reset
//   i_gpio_cmd     host command word  {op[2:0], strobe, ..., arg}
//   o_gpio_rsp     status word        {busy, done, error, ack, 0, data}
//   o_kernel_*     kernel coefficient write port (we, idx, data)
//   o_ram_*        image RAM write port (we, addr, data)
//   o_conv_start   one-cycle run start pulse
//   o_conv_len     number of output words for the run
//   i_conv_done    one-cycle run-complete pulse from the datapath
//   o_res_addr     result RAM read address
//   i_res_data     result RAM read data (one-cycle latency)
//   o_led          {error, done, busy}, one cycle behind the status word
// ---------------------------------------------------------------------------
module conv_gpio_ctrl #(
    parameter int BIT_LEN    = 8,
    parameter int CONV_LEN   = 20,
    parameter int M_LEN      = 3,
    parameter int NB_ADDRESS = 10,
    parameter int GPIO_D     = 32
) (
    input  logic                  CLK100MHZ,
    input  logic                  ck_rst,
    input  logic [GPIO_D-1:0]     i_gpio_cmd,
    output logic [GPIO_D-1:0]     o_gpio_rsp,
    output logic                  o_kernel_we,
    output logic [3:0]            o_kernel_idx,
    output logic [BIT_LEN-1:0]    o_kernel_data,
    output logic                  o_ram_we,
    output logic [NB_ADDRESS-1:0] o_ram_addr,
    output logic [BIT_LEN-1:0]    o_ram_data,
    output logic                  o_conv_start,
    output logic [NB_ADDRESS-1:0] o_conv_len,
    input  logic                  i_conv_done,
    output logic [NB_ADDRESS-1:0] o_res_addr,
    input  logic [CONV_LEN-1:0]   i_res_data,
    output logic [2:0]            o_led
);

    // Argument field wide enough for both pixel/coef data and run length.
    localparam int ARG_W   = (BIT_LEN > NB_ADDRESS) ? BIT_LEN : NB_ADDRESS;
    // Compact command record kept internally: {op[2:0], strobe, arg}.
    localparam int CMD_W   = 4 + ARG_W;
    localparam int STB_BIT = GPIO_D - 4;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_SRST  = 3'd1;
    localparam logic [2:0] OP_LDK   = 3'd2;
    localparam logic [2:0] OP_LDP   = 3'd3;
    localparam logic [2:0] OP_START = 3'd4;
    localparam logic [2:0] OP_RD    = 3'd5;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_RD_WAIT = 2'd2;
    localparam logic [1:0] ST_RD_CAP  = 2'd3;

    localparam logic [3:0]            K_LAST   = 4'(M_LEN * M_LEN - 1);
    localparam logic [NB_ADDRESS-1:0] ADDR_ONE = NB_ADDRESS'(1);

    logic [1:0]            state_reg, state_next;
    logic                  strobe_last_reg, strobe_last_next;
    logic                  pend_valid_reg, pend_valid_next;
    logic [CMD_W-1:0]      pend_cmd_reg, pend_cmd_next;
    logic                  rd_strobe_reg, rd_strobe_next;
    logic                  busy_reg, busy_next;
    logic                  done_reg, done_next;
    logic                  error_reg, error_next;
    logic                  ack_reg, ack_next;
    logic [CONV_LEN-1:0]   rdata_reg, rdata_next;
    logic [3:0]            kidx_reg, kidx_next;
    logic [NB_ADDRESS-1:0] wr_ptr_reg, wr_ptr_next;
    logic [NB_ADDRESS-1:0] rd_ptr_reg, rd_ptr_next;
    logic                  kernel_we_reg, kernel_we_next;
    logic [3:0]            kernel_idx_reg, kernel_idx_next;
    logic [BIT_LEN-1:0]    kernel_data_reg, kernel_data_next;
    logic                  ram_we_reg, ram_we_next;
    logic [NB_ADDRESS-1:0] ram_addr_reg, ram_addr_next;
    logic [BIT_LEN-1:0]    ram_data_reg, ram_data_next;
    logic                  conv_start_reg, conv_start_next;
    logic [NB_ADDRESS-1:0] conv_len_reg, conv_len_next;
    logic [NB_ADDRESS-1:0] res_addr_reg, res_addr_next;
    logic [2:0]            led_reg, led_next;

    logic [CMD_W-1:0]      cmd_in;
    logic                  new_cmd;
    logic [2:0]            cmd_op;
    logic                  exec_valid;
    logic [CMD_W-1:0]      exec_cmd;
    logic [2:0]            exec_op;
    logic                  exec_strobe;
    logic [ARG_W-1:0]      exec_arg;
    logic                  hold_cmd;
    logic                  do_srst;

    // Host bits between the strobe and the argument field carry no meaning.
    logic unused_cmd_bits;
    assign unused_cmd_bits = ^i_gpio_cmd[GPIO_D-5:ARG_W];

    assign cmd_in  = {i_gpio_cmd[GPIO_D-1:GPIO_D-4], i_gpio_cmd[ARG_W-1:0]};
    assign new_cmd = (i_gpio_cmd[STB_BIT] != strobe_last_reg);
    assign cmd_op  = cmd_in[CMD_W-1 -: 3];

    // In IDLE a parked command always goes before a fresh one so that
    // commands execute in the order the host issued them.
    always_comb begin
        exec_valid = 1'b0;
        exec_cmd   = cmd_in;
        if (state_reg == ST_IDLE) begin
            if (pend_valid_reg) begin
                exec_valid = 1'b1;
                exec_cmd   = pend_cmd_reg;
            end else if (new_cmd) begin
                exec_valid = 1'b1;
            end
        end
    end

    assign exec_op     = exec_cmd[CMD_W-1 -: 3];
    assign exec_strobe = exec_cmd[ARG_W];
    assign exec_arg    = exec_cmd[ARG_W-1:0];

    always_comb begin
        state_next       = state_reg;
        strobe_last_next = i_gpio_cmd[STB_BIT];
        pend_valid_next  = pend_valid_reg;
        pend_cmd_next    = pend_cmd_reg;
        rd_strobe_next   = rd_strobe_reg;
        busy_next        = busy_reg;
        done_next        = done_reg;
        error_next       = error_reg;
        ack_next         = ack_reg;
        rdata_next       = rdata_reg;
        kidx_next        = kidx_reg;
        wr_ptr_next      = wr_ptr_reg;
        rd_ptr_next      = rd_ptr_reg;
        kernel_we_next   = 1'b0;
        kernel_idx_next  = kernel_idx_reg;
        kernel_data_next = kernel_data_reg;
        ram_we_next      = 1'b0;
        ram_addr_next    = ram_addr_reg;
        ram_data_next    = ram_data_reg;
        conv_start_next  = 1'b0;
        conv_len_next    = conv_len_reg;
        res_addr_next    = res_addr_reg;
        led_next         = {error_reg, done_reg, busy_reg};
        hold_cmd         = 1'b0;
        do_srst          = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (pend_valid_reg) begin
                    pend_valid_next = 1'b0;
                    hold_cmd        = new_cmd;
                end
            end
            ST_RUN: begin
                if (i_conv_done) begin
                    // Completion wins; a same-cycle command is parked and
                    // runs from IDLE on the next cycle.
                    busy_next   = 1'b0;
                    done_next   = 1'b1;
                    rd_ptr_next = '0;
                    state_next  = ST_IDLE;
                    hold_cmd    = new_cmd;
                end else if (new_cmd) begin
                    ack_next = cmd_in[ARG_W];
                    if (cmd_op == OP_SRST) begin
                        do_srst = 1'b1;
                    end else if (cmd_op != OP_NOP) begin
                        error_next = 1'b1;
                    end
                end
            end
            ST_RD_WAIT: begin
                state_next = ST_RD_CAP;
                hold_cmd   = new_cmd;
            end
            ST_RD_CAP: begin
                rdata_next  = i_res_data;
                ack_next    = rd_strobe_reg;
                rd_ptr_next = rd_ptr_reg + ADDR_ONE;
                state_next  = ST_IDLE;
                hold_cmd    = new_cmd;
            end
            default: state_next = ST_IDLE;
        endcase

        if (exec_valid) begin
            ack_next = exec_strobe;
            case (exec_op)
                OP_NOP: ;
                OP_SRST: do_srst = 1'b1;
                OP_LDK: begin
                    kernel_we_next   = 1'b1;
                    kernel_idx_next  = kidx_reg;
                    kernel_data_next = exec_arg[BIT_LEN-1:0];
                    kidx_next        = (kidx_reg == K_LAST) ? 4'd0 : kidx_reg + 4'd1;
                end
                OP_LDP: begin
                    ram_we_next   = 1'b1;
                    ram_addr_next = wr_ptr_reg;
                    ram_data_next = exec_arg[BIT_LEN-1:0];
                    wr_ptr_next   = wr_ptr_reg + ADDR_ONE;
                    if (&wr_ptr_reg) begin
                        error_next = 1'b1;
                    end
                end
                OP_START: begin
                    if (exec_arg[NB_ADDRESS-1:0] == '0) begin
                        error_next = 1'b1;
                    end else begin
                        conv_start_next = 1'b1;
                        conv_len_next   = exec_arg[NB_ADDRESS-1:0];
                        done_next       = 1'b0;
                        busy_next       = 1'b1;
                        state_next      = ST_RUN;
                    end
                end
                OP_RD: begin
                    // Ack is deferred until the data is captured in RD_CAP.
                    ack_next       = ack_reg;
                    res_addr_next  = rd_ptr_reg;
                    rd_strobe_next = exec_strobe;
                    state_next     = ST_RD_WAIT;
                end
                default: error_next = 1'b1;
            endcase
        end

        if (do_srst) begin
            state_next  = ST_IDLE;
            kidx_next   = '0;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            done_next   = 1'b0;
            error_next  = 1'b0;
            busy_next   = 1'b0;
        end

        // Single-entry pending slot; an overflow drops the command and flags it.
        if (hold_cmd) begin
            if (pend_valid_next) begin
                error_next = 1'b1;
            end else begin
                pend_valid_next = 1'b1;
                pend_cmd_next   = cmd_in;
            end
        end
    end

    always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
        if (!ck_rst) begin
            state_reg       <= ST_IDLE;
            strobe_last_reg <= 1'b0;
            pend_valid_reg  <= 1'b0;
            pend_cmd_reg    <= '0;
            rd_strobe_reg   <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            error_reg       <= 1'b0;
            ack_reg         <= 1'b0;
            rdata_reg       <= '0;
            kidx_reg        <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            kernel_we_reg   <= 1'b0;
            kernel_idx_reg  <= '0;
            kernel_data_reg <= '0;
            ram_we_reg      <= 1'b0;
            ram_addr_reg    <= '0;
            ram_data_reg    <= '0;
            conv_start_reg  <= 1'b0;
            conv_len_reg    <= '0;
            res_addr_reg    <= '0;
            led_reg         <= '0;
        end else begin
            state_reg       <= state_next;
            strobe_last_reg <= strobe_last_next;
            pend_valid_reg  <= pend_valid_next;
            pend_cmd_reg    <= pend_cmd_next;
            rd_strobe_reg   <= rd_strobe_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
            error_reg       <= error_next;
            ack_reg         <= ack_next;
            rdata_reg       <= rdata_next;
            kidx_reg        <= kidx_next;
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            kernel_we_reg   <= kernel_we_next;
            kernel_idx_reg  <= kernel_idx_next;
            kernel_data_reg <= kernel_data_next;
            ram_we_reg      <= ram_we_next;
            ram_addr_reg    <= ram_addr_next;
            ram_data_reg    <= ram_data_next;
            conv_start_reg  <= conv_start_next;
            conv_len_reg    <= conv_len_next;
            res_addr_reg    <= res_addr_next;
            led_reg         <= led_next;
        end
    end

    always_comb begin
        o_gpio_rsp                 = '0;
        o_gpio_rsp[GPIO_D-1]       = busy_reg;
        o_gpio_rsp[GPIO_D-2]       = done_reg;
        o_gpio_rsp[GPIO_D-3]       = error_reg;
        o_gpio_rsp[GPIO_D-4]       = ack_reg;
        o_gpio_rsp[CONV_LEN-1:0]   = rdata_reg;
    end

    assign o_kernel_we   = kernel_we_reg;
    assign o_kernel_idx  = kernel_idx_reg;
    assign o_kernel_data = kernel_data_reg;
    assign o_ram_we      = ram_we_reg;
    assign o_ram_addr    = ram_addr_reg;
    assign o_ram_data    = ram_data_reg;
    assign o_conv_start  = conv_start_reg;
    assign o_conv_len    = conv_len_reg;
    assign o_res_addr    = res_addr_reg;
    assign o_led         = led_reg;

endmodule

// File: tb/tb_conv_gpio_ctrl.sv
// ---------------------------------------------------------------------------
// tb_conv_gpio_ctrl
//
// Self-checking bench for conv_gpio_ctrl. A host-level model (kernel index,
// write/read pointers, sticky status flags) predicts every pulse and status
// value; a result RAM model answers reads with one cycle of latency.
// ---------------------------------------------------------------------------
module tb_conv_gpio_ctrl;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_SRST  = 3'd1;
    localparam logic [2:0] OP_LDK   = 3'd2;
    localparam logic [2:0] OP_LDP   = 3'd3;
    localparam logic [2:0] OP_START = 3'd4;
    localparam logic [2:0] OP_RD    = 3'd5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cmd;
    logic [31:0] rsp;
    logic        kernel_we;
    logic [3:0]  kernel_idx;
    logic [7:0]  kernel_data;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [7:0]  ram_data;
    logic        conv_start;
    logic [9:0]  conv_len;
    logic        conv_done;
    logic [9:0]  res_addr;
    logic [19:0] res_data;
    logic [2:0]  led;

    always #5 clk = ~clk;

    conv_gpio_ctrl dut (
        .CLK100MHZ    (clk),
        .ck_rst       (rst_n),
        .i_gpio_cmd   (cmd),
        .o_gpio_rsp   (rsp),
        .o_kernel_we  (kernel_we),
        .o_kernel_idx (kernel_idx),
        .o_kernel_data(kernel_data),
        .o_ram_we     (ram_we),
        .o_ram_addr   (ram_addr),
        .o_ram_data   (ram_data),
        .o_conv_start (conv_start),
        .o_conv_len   (conv_len),
        .i_conv_done  (conv_done),
        .o_res_addr   (res_addr),
        .i_res_data   (res_data),
        .o_led        (led)
    );

    // Result RAM model, registered read.
    logic [19:0] res_mem [0:1023];
    always @(posedge clk) res_data <= res_mem[res_addr];

    // Pulse monitor: counts write/start strobes and keeps the last payload.
    int         kwe_cnt = 0;
    int         rwe_cnt = 0;
    int         cs_cnt  = 0;
    logic [3:0] mon_kidx;
    logic [7:0] mon_kdata;
    logic [9:0] mon_raddr;
    logic [7:0] mon_rdata;
    always @(negedge clk) begin
        if (kernel_we) begin
            kwe_cnt++;
            mon_kidx  = kernel_idx;
            mon_kdata = kernel_data;
        end
        if (ram_we) begin
            rwe_cnt++;
            mon_raddr = ram_addr;
            mon_rdata = ram_data;
        end
        if (conv_start) cs_cnt++;
    end

    int   n_checks = 0;
    int   n_fail   = 0;
    logic strobe;
    int   lat, d_kwe, d_rwe, d_cs;

    // Host-level model
    int   m_kidx, m_wr, m_rd;
    logic m_err, m_done, m_busy;

    // Issue one command, wait for ack == strobe, then let pulses settle.
    task automatic do_cmd(input logic [2:0] op, input logic [9:0] arg);
        int k0, r0, c0;
        k0 = kwe_cnt; r0 = rwe_cnt; c0 = cs_cnt;
        @(posedge clk); #1;
        strobe = ~strobe;
        cmd    = {op, strobe, 18'd0, arg};
        lat    = 0;
        while ((rsp[28] !== strobe) && (lat < 20)) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (rsp[28] !== strobe) begin
            n_fail++;
            $display("FAIL ack_timeout: op=%0d ack=%b required=%b", op, rsp[28], strobe);
        end
        repeat (2) @(posedge clk);
        #1;
        d_kwe = kwe_cnt - k0;
        d_rwe = rwe_cnt - r0;
        d_cs  = cs_cnt - c0;
        $display("txn op=%0d arg=%03h lat=%0d rsp=%08h led=%b", op, arg, lat, rsp, led);
    endtask

    task automatic pulse_done();
        @(posedge clk); #1;
        conv_done = 1'b1;
        @(posedge clk); #1;
        conv_done = 1'b0;
        @(posedge clk); #1;
        $display("txn conv_done rsp=%08h led=%b", rsp, led);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd = '0; strobe = 1'b0; conv_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (rsp !== 32'h0) begin
            n_fail++; $display("FAIL reset_rsp: got %08h required 00000000", rsp);
        end
        n_checks++;
        if ({kernel_we, ram_we, conv_start, led} !== 6'b0) begin
            n_fail++; $display("FAIL reset_pulses: got %b required 000000", {kernel_we, ram_we, conv_start, led});
        end
        n_checks++;
        if ({kernel_idx, ram_addr, conv_len, res_addr} !== 34'h0) begin
            n_fail++; $display("FAIL reset_regs: got %h required 0", {kernel_idx, ram_addr, conv_len, res_addr});
        end
        rst_n = 1'b1;
        m_kidx = 0; m_wr = 0; m_rd = 0;
        m_err = 1'b0; m_done = 1'b0; m_busy = 1'b0;
        $display("txn reset released");
    endtask

    task automatic test_kernel();
        for (int i = 0; i < 10; i++) begin
            logic [7:0] d;
            d = (i < 9) ? 8'(i + 1) : 8'($urandom_range(0, 255));
            do_cmd(OP_LDK, {2'b00, d});
            n_checks++;
            if (d_kwe !== 1 || mon_kidx !== 4'(m_kidx) || mon_kdata !== d || lat !== 1) begin
                n_fail++;
                $display("FAIL kernel_load: got we=%0d idx=%0d data=%02h lat=%0d required we=1 idx=%0d data=%02h lat=1",
                         d_kwe, mon_kidx, mon_kdata, lat, m_kidx, d);
            end
            m_kidx = (m_kidx + 1) % 9;
        end
    endtask

    task automatic test_pixels();
        for (int i = 0; i < 1025; i++) begin
            logic [9:0] a;
            logic [7:0] d;
            a = 10'(m_wr);
            d = a[7:0];
            do_cmd(OP_LDP, {2'b00, d});
            if (m_wr == 1023) m_err = 1'b1;
            m_wr = (m_wr + 1) % 1024;
            n_checks++;
            if (d_rwe !== 1 || mon_raddr !== a || mon_rdata !== d || rsp[29] !== m_err) begin
                n_fail++;
                $display("FAIL pixel_load: got we=%0d addr=%0d data=%02h err=%b required we=1 addr=%0d data=%02h err=%b",
                         d_rwe, mon_raddr, mon_rdata, rsp[29], a, d, m_err);
            end
        end
        n_checks++;
        if (led !== {m_err, m_done, m_busy}) begin
            n_fail++; $display("FAIL pixel_led: got %b required %b", led, {m_err, m_done, m_busy});
        end
    endtask

    task automatic test_soft_reset();
        do_cmd(OP_SRST, 10'd0);
        m_kidx = 0; m_wr = 0; m_rd = 0;
        m_err = 1'b0; m_done = 1'b0; m_busy = 1'b0;
        n_checks++;
        if (rsp[31:29] !== 3'b000 || led !== 3'b000 || lat !== 1) begin
            n_fail++; $display("FAIL soft_reset: got status=%b led=%b lat=%0d required 000 000 1", rsp[31:29], led, lat);
        end
    endtask

    task automatic test_run();
        do_cmd(OP_START, 10'd16);
        m_busy = 1'b1; m_done = 1'b0;
        n_checks++;
        if (d_cs !== 1 || conv_len !== 10'd16 || rsp[31:29] !== {m_busy, m_done, m_err}) begin
            n_fail++; $display("FAIL run_start: got starts=%0d len=%0d status=%b required 1 16 %b",
                               d_cs, conv_len, rsp[31:29], {m_busy, m_done, m_err});
        end
        do_cmd(OP_LDP, 10'($urandom_range(0, 255)));
        m_err = 1'b1;
        n_checks++;
        if (d_rwe !== 0 || lat !== 1 || rsp[31:29] !== {m_busy, m_done, m_err}) begin
            n_fail++; $display("FAIL run_reject: got we=%0d lat=%0d status=%b required 0 1 %b",
                               d_rwe, lat, rsp[31:29], {m_busy, m_done, m_err});
        end
        do_cmd(OP_NOP, 10'd0);
        n_checks++;
        if (lat !== 1 || rsp[31:29] !== {m_busy, m_done, m_err}) begin
            n_fail++; $display("FAIL run_nop: got lat=%0d status=%b required 1 %b", lat, rsp[31:29], {m_busy, m_done, m_err});
        end
        pulse_done();
        m_busy = 1'b0; m_done = 1'b1; m_rd = 0;
        @(posedge clk); #1;
        n_checks++;
        if (rsp[31:29] !== {m_busy, m_done, m_err} || led !== {m_err, m_done, m_busy}) begin
            n_fail++; $display("FAIL run_done: got status=%b led=%b required %b %b",
                               rsp[31:29], led, {m_busy, m_done, m_err}, {m_err, m_done, m_busy});
        end
    endtask

    task automatic test_read();
        for (int i = 0; i < 3; i++) begin
            do_cmd(OP_RD, 10'd0);
            n_checks++;
            if (lat !== 3 || res_addr !== 10'(m_rd) || rsp[19:0] !== res_mem[m_rd] || rsp[27:20] !== 8'h0) begin
                n_fail++; $display("FAIL read: got lat=%0d addr=%0d data=%05h required 3 %0d %05h",
                                   lat, res_addr, rsp[19:0], m_rd, res_mem[m_rd]);
            end
            m_rd = m_rd + 1;
        end
        // Done pulse outside RUN must not touch status or the read pointer.
        pulse_done();
        do_cmd(OP_RD, 10'd0);
        n_checks++;
        if (res_addr !== 10'(m_rd) || rsp[19:0] !== res_mem[m_rd] || rsp[31:29] !== {m_busy, m_done, m_err}) begin
            n_fail++; $display("FAIL read_idle_done: got addr=%0d data=%05h status=%b required %0d %05h %b",
                               res_addr, rsp[19:0], rsp[31:29], m_rd, res_mem[m_rd], {m_busy, m_done, m_err});
        end
        m_rd = m_rd + 1;
    endtask

    task automatic test_start_zero();
        logic [7:0] d;
        do_cmd(OP_SRST, 10'd0);
        m_kidx = 0; m_wr = 0; m_rd = 0; m_err = 1'b0; m_done = 1'b0; m_busy = 1'b0;
        do_cmd(OP_START, 10'd0);
        m_err = 1'b1;
        n_checks++;
        if (d_cs !== 0 || rsp[31:29] !== {m_busy, m_done, m_err} || lat !== 1) begin
            n_fail++; $display("FAIL start_zero: got starts=%0d status=%b lat=%0d required 0 %b 1",
                               d_cs, rsp[31:29], lat, {m_busy, m_done, m_err});
        end
        do_cmd(OP_SRST, 10'd0);
        m_err = 1'b0;
        n_checks++;
        if (rsp[29] !== m_err) begin
            n_fail++; $display("FAIL srst_clear: got err=%b required %b", rsp[29], m_err);
        end
        d = 8'($urandom_range(0, 255));
        do_cmd(OP_LDK, {2'b00, d});
        n_checks++;
        if (d_kwe !== 1 || mon_kidx !== 4'(m_kidx) || mon_kdata !== d) begin
            n_fail++; $display("FAIL srst_kidx: got idx=%0d data=%02h required %0d %02h", mon_kidx, mon_kdata, m_kidx, d);
        end
        m_kidx = m_kidx + 1;
        do_cmd(OP_LDP, {2'b00, d});
        n_checks++;
        if (d_rwe !== 1 || mon_raddr !== 10'(m_wr)) begin
            n_fail++; $display("FAIL srst_wptr: got addr=%0d required %0d", mon_raddr, m_wr);
        end
        m_wr = m_wr + 1;
        do_cmd(OP_RD, 10'd0);
        n_checks++;
        if (res_addr !== 10'(m_rd) || rsp[19:0] !== res_mem[m_rd]) begin
            n_fail++; $display("FAIL srst_rptr: got addr=%0d data=%05h required %0d %05h", res_addr, rsp[19:0], m_rd, res_mem[m_rd]);
        end
        m_rd = m_rd + 1;
    endtask

    task automatic test_random_mix();
        for (int i = 0; i < 40; i++) begin
            logic [2:0] op;
            logic [9:0] arg;
            int         pick, exp_kwe, exp_rwe, exp_kidx, exp_wr;
            pick = $urandom_range(0, 4);
            op   = (pick == 0) ? OP_NOP : (pick == 1) ? OP_LDK : (pick == 2) ? OP_LDP : 3'(pick + 3);
            arg  = 10'($urandom_range(0, 1023));
            exp_kwe = 0; exp_rwe = 0; exp_kidx = m_kidx; exp_wr = m_wr;
            if (op == OP_LDK) begin
                exp_kwe = 1; m_kidx = (m_kidx + 1) % 9;
            end else if (op == OP_LDP) begin
                exp_rwe = 1;
                if (m_wr == 1023) m_err = 1'b1;
                m_wr = (m_wr + 1) % 1024;
            end else if (op != OP_NOP) begin
                m_err = 1'b1;
            end
            do_cmd(op, arg);
            n_checks++;
            if (d_kwe !== exp_kwe || d_rwe !== exp_rwe || rsp[29] !== m_err || lat !== 1) begin
                n_fail++; $display("FAIL mix op=%0d: got kwe=%0d rwe=%0d err=%b lat=%0d required %0d %0d %b 1",
                                   op, d_kwe, d_rwe, rsp[29], lat, exp_kwe, exp_rwe, m_err);
            end
            if (exp_kwe == 1) begin
                n_checks++;
                if (mon_kidx !== 4'(exp_kidx) || mon_kdata !== arg[7:0]) begin
                    n_fail++; $display("FAIL mix_kernel: got idx=%0d data=%02h required %0d %02h", mon_kidx, mon_kdata, exp_kidx, arg[7:0]);
                end
            end
            if (exp_rwe == 1) begin
                n_checks++;
                if (mon_raddr !== 10'(exp_wr) || mon_rdata !== arg[7:0]) begin
                    n_fail++; $display("FAIL mix_pixel: got addr=%0d data=%02h required %0d %02h", mon_raddr, mon_rdata, exp_wr, arg[7:0]);
                end
            end
        end
    endtask

    task automatic test_done_collision();
        logic [7:0] d;
        int         k0;
        do_cmd(OP_START, 10'($urandom_range(1, 1023)));
        m_busy = 1'b1; m_done = 1'b0;
        n_checks++;
        if (d_cs !== 1 || rsp[31] !== 1'b1) begin
            n_fail++; $display("FAIL coll_start: got starts=%0d busy=%b required 1 1", d_cs, rsp[31]);
        end
        d  = 8'($urandom_range(0, 255));
        k0 = kwe_cnt;
        @(posedge clk); #1;
        strobe    = ~strobe;
        cmd       = {OP_LDK, strobe, 18'd0, 2'b00, d};
        conv_done = 1'b1;
        @(posedge clk); #1;
        conv_done = 1'b0;
        m_busy = 1'b0; m_done = 1'b1; m_rd = 0;
        n_checks++;
        if (rsp[28] === strobe || rsp[31:29] !== {m_busy, m_done, m_err}) begin
            n_fail++; $display("FAIL coll_first: got ack=%b status=%b required ack=%b status=%b",
                               rsp[28], rsp[31:29], ~strobe, {m_busy, m_done, m_err});
        end
        @(posedge clk); #1;
        n_checks++;
        if (rsp[28] !== strobe) begin
            n_fail++; $display("FAIL coll_ack: got ack=%b required %b", rsp[28], strobe);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (kwe_cnt - k0 !== 1 || mon_kidx !== 4'(m_kidx) || mon_kdata !== d || rsp[29] !== m_err) begin
            n_fail++; $display("FAIL coll_exec: got we=%0d idx=%0d data=%02h err=%b required 1 %0d %02h %b",
                               kwe_cnt - k0, mon_kidx, mon_kdata, rsp[29], m_kidx, d, m_err);
        end
        m_kidx = (m_kidx + 1) % 9;
        $display("txn collision done+ldk rsp=%08h", rsp);
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        int         k0;
        d  = 8'($urandom_range(0, 255));
        k0 = kwe_cnt;
        @(posedge clk); #1;
        strobe = ~strobe;
        cmd    = {OP_RD, strobe, 28'd0};
        @(posedge clk); #1;
        strobe = ~strobe;
        cmd    = {OP_LDK, strobe, 18'd0, 2'b00, d};
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (rsp[28] !== ~strobe || rsp[19:0] !== res_mem[m_rd] || res_addr !== 10'(m_rd)) begin
            n_fail++; $display("FAIL b2b_read: got ack=%b data=%05h addr=%0d required %b %05h %0d",
                               rsp[28], rsp[19:0], res_addr, ~strobe, res_mem[m_rd], m_rd);
        end
        m_rd = m_rd + 1;
        @(posedge clk); #1;
        n_checks++;
        if (rsp[28] !== strobe) begin
            n_fail++; $display("FAIL b2b_ack: got ack=%b required %b", rsp[28], strobe);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (kwe_cnt - k0 !== 1 || mon_kidx !== 4'(m_kidx) || mon_kdata !== d || rsp[29] !== m_err) begin
            n_fail++; $display("FAIL b2b_exec: got we=%0d idx=%0d data=%02h err=%b required 1 %0d %02h %b",
                               kwe_cnt - k0, mon_kidx, mon_kdata, rsp[29], m_kidx, d, m_err);
        end
        m_kidx = (m_kidx + 1) % 9;
        $display("txn back_to_back rd+ldk rsp=%08h", rsp);
    endtask

    task automatic test_async_reset();
        int k0;
        do_cmd(OP_START, 10'd8);
        n_checks++;
        if (rsp[31] !== 1'b1 || conv_len !== 10'd8) begin
            n_fail++; $display("FAIL areset_run: got busy=%b len=%0d required 1 8", rsp[31], conv_len);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rsp !== 32'h0 || led !== 3'b0 || {kernel_we, ram_we, conv_start} !== 3'b0 ||
            {kernel_idx, kernel_data, ram_addr, ram_data, conv_len, res_addr} !== 50'h0) begin
            n_fail++; $display("FAIL areset_outputs: got rsp=%08h led=%b len=%0d addr=%0d required all zero",
                               rsp, led, conv_len, res_addr);
        end
        k0     = kwe_cnt;
        strobe = 1'b1;
        cmd    = {OP_LDK, 1'b1, 18'd0, 10'h0A5};
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (kwe_cnt - k0 !== 1 || mon_kidx !== 4'd0 || mon_kdata !== 8'hA5 || rsp[28] !== 1'b1 || rsp[31:29] !== 3'b000) begin
            n_fail++; $display("FAIL areset_strobe: got we=%0d idx=%0d data=%02h ack=%b status=%b required 1 0 a5 1 000",
                               kwe_cnt - k0, mon_kidx, mon_kdata, rsp[28], rsp[31:29]);
        end
        $display("txn async reset and held strobe rsp=%08h", rsp);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) res_mem[i] = 20'($urandom);
        res_mem[0] = 20'h12345;
        res_mem[1] = 20'hFFFFF;
        res_mem[2] = 20'h00001;

        test_reset();
        test_kernel();
        test_pixels();
        test_soft_reset();
        test_run();
        test_read();
        test_start_zero();
        test_random_mix();
        test_done_collision();
        test_back_to_back();
        test_async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
